// File: rtl/usb_rx_pkg.sv
// Shared constants for the USB receive clock/data recovery path.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a.
package usb_rx_pkg;

  // Sampling slots per bit period, and the bit period in fast clock cycles
  localparam int SLOTS         = 5;
  localparam int BIT_PERIOD    = 10;

  // Decoded 1s allowed before a stuffed 0 must follow
  localparam int STUFF_LEN_DEF = 6;

  // Idle line level (J state), also the NRZI reference after reset/flush
  localparam logic J_LEVEL     = 1'b1;

  // Phase-clock bit that produces each slot, listed in time order (slot 0 first)
  localparam int SLOT_BIT [SLOTS] = '{0, 4, 3, 2, 1};

  // Window alignment: wait for a slot0 strobe, then collect whole windows
  typedef enum logic {
    ALIGN_WAIT = 1'b0,
    ALIGN_RUN  = 1'b1
  } align_state_e;

  // Sample slot chosen for a given best edge boundary: two slots past the edge
  function automatic logic [2:0] phase_of(input logic [2:0] best);
    phase_of = (best >= 3'd3) ? (best - 3'd3) : (best + 3'd2);
  endfunction

endpackage

// File: rtl/rx_bit_unstuff.sv
// NRZI decode of one raw bit per window followed by bit-stuff removal/checking.
// Latency: 1 cycle from raw_vld to bit_vld/stuff_err (registered).
// Backpressure: none; one raw bit in, at most one decoded bit out, en=0 flushes.
module rx_bit_unstuff
  import usb_rx_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic raw_bit,
  input  logic raw_vld,
  output logic bit_dat,
  output logic bit_vld,
  output logic stuff_err
);

  localparam int ONES_W = $clog2(STUFF_LEN + 1);

  logic              last_q;
  logic [ONES_W-1:0] ones_q;
  logic              dat_q;
  logic              vld_q;
  logic              err_q;
  logic              decoded;

  // NRZI: no change on the line is a 1, a change is a 0
  assign decoded = (raw_bit == last_q);

  // Track line history and run length of 1s; drop the bit after a full run
  always_ff @(posedge clock) begin
    if (reset || !en) begin
      last_q <= J_LEVEL;
      ones_q <= '0;
      dat_q  <= 1'b0;
      vld_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      err_q <= 1'b0;
      if (raw_vld) begin
        last_q <= raw_bit;
        if (ones_q < ONES_W'(STUFF_LEN)) begin
          vld_q  <= 1'b1;
          dat_q  <= decoded;
          ones_q <= decoded ? (ones_q + 1'b1) : '0;
        end else begin
          // This slot must carry the stuffed 0; a 1 here is a violation
          ones_q <= '0;
          err_q  <= decoded;
        end
      end
    end
  end

  // Gating by en kills a pulse already sitting in the output register
  assign bit_dat   = dat_q;
  assign bit_vld   = vld_q & en;
  assign stuff_err = err_q & en;

endmodule

// File: rtl/usb_rx_cdr.sv
// Oversampling CDR: 5 phase strobes per bit, edge histogram picks the centre sample, then NRZI/unstuff.
// Latency: rx_valid/rx_data/rx_stuff_err 2 cycles after the slot4 strobe cycle.
// Backpressure: none; at most one output bit per 10-cycle window, rx_en=0 flushes all state.
module usb_rx_cdr
  import usb_rx_pkg::*;
#(
  parameter int CNT_W     = 4,
  parameter int STUFF_LEN = STUFF_LEN_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] clock_x5,
  input  logic       rx_d,
  input  logic       rx_en,
  output logic       rx_data,
  output logic       rx_valid,
  output logic       rx_stuff_err,
  output logic [2:0] rx_phase
);

  // A counter holding this value would hit all-ones on its next increment
  localparam logic [CNT_W-1:0] HIST_TOP = CNT_W'((1 << CNT_W) - 2);

  logic [4:0]       ph_q;
  logic [4:0]       chg;
  logic             stb;
  logic [2:0]       stb_slot;
  align_state_e     state_q;
  align_state_e     state_d;
  logic             cap;
  logic [SLOTS-1:0] s_q;
  logic             s4_prev_q;
  logic             win_done_q;
  logic             win_vld;
  logic [CNT_W-1:0] hist_q [SLOTS];
  logic [CNT_W-1:0] hist_max;
  logic [SLOTS-1:0] trans;
  logic             rescale;
  logic [2:0]       best_q;
  logic [2:0]       best_d;
  logic             raw_bit;

  assign chg     = clock_x5 ^ ph_q;
  assign win_vld = win_done_q & rx_en;

  // Previous phase-clock levels; any bit difference is a sampling strobe
  always_ff @(posedge clock) begin
    if (reset) ph_q <= 5'b0;
    else       ph_q <= clock_x5;
  end

  // Map the changed phase bit to its slot; on multiple changes the lowest slot wins
  always_comb begin
    stb      = 1'b0;
    stb_slot = 3'd0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (chg[SLOT_BIT[i]]) begin
        stb      = 1'b1;
        stb_slot = 3'(i);
      end
    end
  end

  // Alignment state register
  always_ff @(posedge clock) begin
    if (reset) state_q <= ALIGN_WAIT;
    else       state_q <= state_d;
  end

  // Start capturing only at a slot0 strobe so every window is slot0..slot4
  always_comb begin
    state_d = state_q;
    cap     = 1'b0;
    if (!rx_en) begin
      state_d = ALIGN_WAIT;
    end else begin
      case (state_q)
        ALIGN_WAIT: begin
          if (stb && (stb_slot == 3'd0)) begin
            state_d = ALIGN_RUN;
            cap     = 1'b1;
          end
        end
        ALIGN_RUN: cap = stb;
        default:   state_d = ALIGN_WAIT;
      endcase
    end
  end

  // Capture line samples per slot; the slot4 capture closes the window
  always_ff @(posedge clock) begin
    if (reset) begin
      s_q        <= {SLOTS{J_LEVEL}};
      win_done_q <= 1'b0;
    end else begin
      win_done_q <= cap && (stb_slot == 3'(SLOTS - 1));
      if (cap) s_q[stb_slot] <= rx_d;
    end
  end

  // Which boundaries saw an edge this window, and whether any counter would saturate
  always_comb begin
    trans    = '0;
    rescale  = 1'b0;
    trans[0] = s4_prev_q ^ s_q[0];
    for (int b = 1; b < SLOTS; b++) trans[b] = s_q[b-1] ^ s_q[b];
    for (int b = 0; b < SLOTS; b++) begin
      if (trans[b] && (hist_q[b] == HIST_TOP)) rescale = 1'b1;
    end
  end

  // Edge histogram; halving all bins together keeps their ratios
  always_ff @(posedge clock) begin
    if (reset || !rx_en) begin
      for (int b = 0; b < SLOTS; b++) hist_q[b] <= '0;
      s4_prev_q <= J_LEVEL;
    end else if (win_vld) begin
      s4_prev_q <= s_q[SLOTS-1];
      for (int b = 0; b < SLOTS; b++) begin
        hist_q[b] <= (rescale ? (hist_q[b] >> 1) : hist_q[b]) + CNT_W'(trans[b]);
      end
    end
  end

  // Argmax of the histogram; the current choice is sticky on ties
  always_comb begin
    hist_max = hist_q[0];
    best_d   = 3'd0;
    for (int b = 1; b < SLOTS; b++) begin
      if (hist_q[b] > hist_max) begin
        hist_max = hist_q[b];
        best_d   = 3'(b);
      end
    end
    if (hist_q[best_q] == hist_max) best_d = best_q;
  end

  // Selected boundary; it settles long before the next window completes
  always_ff @(posedge clock) begin
    if (reset || !rx_en) best_q <= 3'd0;
    else                 best_q <= best_d;
  end

  assign rx_phase = phase_of(best_q);
  assign raw_bit  = s_q[rx_phase];

  rx_bit_unstuff #(
    .STUFF_LEN (STUFF_LEN)
  ) u_unstuff (
    .clock     (clock),
    .reset     (reset),
    .en        (rx_en),
    .raw_bit   (raw_bit),
    .raw_vld   (win_vld),
    .bit_dat   (rx_data),
    .bit_vld   (rx_valid),
    .stuff_err (rx_stuff_err)
  );

endmodule

// File: tb/tb_usb_rx_cdr.sv
// Directed bench for usb_rx_cdr: drives a 5-phase strobe generator and line patterns.
// Latency: checks first-output timing relative to the first complete window.
// Backpressure: n/a; counts output pulses per phase of the run.
module tb_usb_rx_cdr;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] clock_x5;
  logic       rx_d;
  logic       rx_en;
  logic       rx_data;
  logic       rx_valid;
  logic       rx_stuff_err;
  logic [2:0] rx_phase;

  int n_run  = 0;
  int n_fail = 0;

  int cyc_n = 0;
  int pcnt  = 9;
  int mode  = 0;
  int pidx  = 0;
  logic [7:0] pat = 8'b0011_1111;

  int n_valid;
  int n_one;
  int n_zero;
  int n_err;
  int n_gap;
  int first_cyc;
  int err_cyc;

  usb_rx_cdr #(
    .CNT_W     (4),
    .STUFF_LEN (6)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .clock_x5     (clock_x5),
    .rx_d         (rx_d),
    .rx_en        (rx_en),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_stuff_err (rx_stuff_err),
    .rx_phase     (rx_phase)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input int got, input int exp);
    n_run++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clr();
    n_valid   = 0;
    n_one     = 0;
    n_zero    = 0;
    n_err     = 0;
    n_gap     = 0;
    first_cyc = -1;
    err_cyc   = -1;
  endtask

  // One clock: observe outputs after the edge, then advance phases and the line
  task automatic tick();
    @(posedge clock);
    #1;
    cyc_n++;
    if (rx_valid) begin
      n_valid++;
      if (rx_data) n_one++;
      else         n_zero++;
      if (first_cyc < 0) first_cyc = cyc_n;
    end
    if (rx_stuff_err) begin
      n_err++;
      if (err_cyc < 0) err_cyc = cyc_n;
    end
    if (!rx_en && (rx_valid || rx_stuff_err)) n_gap++;
    pcnt = (pcnt == 9) ? 0 : pcnt + 1;
    case (pcnt)
      0: clock_x5[0] = ~clock_x5[0];
      2: clock_x5[4] = ~clock_x5[4];
      4: clock_x5[3] = ~clock_x5[3];
      6: clock_x5[2] = ~clock_x5[2];
      8: clock_x5[1] = ~clock_x5[1];
      default: ;
    endcase
    if (mode == 1 && pcnt == 0) rx_d = ~rx_d;
    if (mode == 2 && pcnt == 4) rx_d = ~rx_d;
    if (mode == 3 && pcnt == 0) begin
      rx_d = pat[pidx];
      if (pidx < 7) pidx++;
    end
  endtask

  task automatic run_to(input int c);
    while (cyc_n < c) tick();
  endtask

  initial begin
    reset    = 1'b1;
    rx_en    = 1'b1;
    rx_d     = 1'b1;
    clock_x5 = 5'b0;
    clr();

    // Reset held while the phase generator runs; released with all phases low
    run_to(20);
    chk("reset_valid", rx_valid, 0);
    chk("reset_data", rx_data, 0);
    chk("reset_err", rx_stuff_err, 0);
    chk("reset_phase", rx_phase, 2);
    reset = 1'b0;
    clr();

    // Idle line: six decoded 1s, then a stuff error on window 7
    run_to(100);
    chk("idle_first_valid_cyc", first_cyc, 31);
    chk("idle_valid_cnt", n_valid, 6);
    chk("idle_one_cnt", n_one, 6);
    chk("idle_err_cnt", n_err, 1);
    chk("idle_err_cyc", err_cyc, 91);
    chk("idle_phase", rx_phase, 2);

    // Disable while window 8 is completing: its bit must never appear
    rx_en = 1'b0;
    clr();
    run_to(110);
    chk("flush_pulses", n_valid + n_err, 0);

    // Edges on slot0: boundary 0 wins, every bit decodes to 0
    rx_en = 1'b1;
    mode  = 1;
    clr();
    run_to(171);
    chk("slot0_valid_cnt", n_valid, 6);
    chk("slot0_zero_cnt", n_zero, 6);
    chk("slot0_err_cnt", n_err, 0);
    chk("slot0_phase", rx_phase, 2);

    // Edges on slot2 after a flush: selection moves to slot 4
    rx_en = 1'b0;
    mode  = 0;
    rx_d  = 1'b1;
    run_to(180);
    rx_en = 1'b1;
    mode  = 2;
    clr();
    run_to(200);
    chk("slot2_phase_early", rx_phase, 4);
    run_to(231);
    chk("slot2_valid_cnt", n_valid, 5);
    chk("slot2_zero_cnt", n_zero, 5);
    chk("slot2_err_cnt", n_err, 0);
    chk("slot2_phase", rx_phase, 4);

    // Drop enable mid-window for 25 cycles
    clr();
    run_to(235);
    rx_en = 1'b0;
    mode  = 0;
    rx_d  = 1'b1;
    run_to(259);
    chk("gap_valid_cnt", n_valid, 0);
    chk("gap_err_cnt", n_err + n_gap, 0);
    chk("gap_phase", rx_phase, 2);

    // Re-enable on a slot4 strobe; decoded 1x6, stuffed 0, 1
    rx_en = 1'b1;
    mode  = 3;
    pidx  = 0;
    clr();
    run_to(341);
    chk("stuff_first_valid_cyc", first_cyc, 271);
    chk("stuff_valid_cnt", n_valid, 7);
    chk("stuff_one_cnt", n_one, 7);
    chk("stuff_err_cnt", n_err, 0);
    chk("stuff_phase", rx_phase, 2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
